// File: rtl/demux_pkg.sv
// Shared definitions for the 1:2 word demultiplexer: width default, slot
// pointer encodings and alignment state encodings.
package demux_pkg;

    localparam int DW_DEFAULT = 8;

    typedef enum logic {
        LANE0 = 1'b0,
        LANE1 = 1'b1
    } sel_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } align_state_t;

endpackage

// File: rtl/demux_lane.sv
// Per-lane publish register: on load, valid follows v and data is refreshed
// only when v is set, so an invalid slot leaves the old word on the lane.
module demux_lane #(
    parameter int DW = 8
) (
    input  logic          clk_2f,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] d,
    input  logic          v,
    output logic [DW-1:0] data,
    output logic          valid
);

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            valid <= v;
            if (v) begin
                data <= d;
            end
        end
    end

endmodule

// File: rtl/demux_l1.sv
// 1:2 demultiplexer from a clk_2f word stream onto two lanes updated together
// every second cycle. Define DEMUX_L1_ALIGN_EN to start pairing on the first
// valid word after idle instead of free-running from reset.
module demux_l1
    import demux_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk_2f,
    input  logic          reset,
    input  logic [DW-1:0] data_00,
    input  logic          valid_00,
    output logic [DW-1:0] data_0,
    output logic          valid_0,
    output logic [DW-1:0] data_1,
    output logic          valid_1,
    output logic          out_stb,
    output logic [7:0]    pair_cnt
);

    sel_t          sel;
    sel_t          sel_n;
    logic          cap;
    logic          pub;
    logic [DW-1:0] hold_0;
    logic          hold_v0;

`ifdef DEMUX_L1_ALIGN_EN
    align_state_t state;
    align_state_t state_n;

    // IDLE always sits on the lane-0 slot, so a LANE1 slot implies ACTIVE.
    always_comb begin
        sel_n   = sel;
        cap     = 1'b0;
        pub     = 1'b0;
        state_n = state;
        if (sel == LANE1) begin
            pub   = 1'b1;
            sel_n = LANE0;
            if (!hold_v0 && !valid_00) begin
                state_n = IDLE;
            end
        end else if (state == ACTIVE || valid_00) begin
            cap     = 1'b1;
            sel_n   = LANE1;
            state_n = ACTIVE;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end
`else
    always_comb begin
        sel_n = sel;
        cap   = 1'b0;
        pub   = 1'b0;
        if (sel == LANE1) begin
            pub   = 1'b1;
            sel_n = LANE0;
        end else begin
            cap   = 1'b1;
            sel_n = LANE1;
        end
    end
`endif

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            sel      <= LANE0;
            hold_0   <= '0;
            hold_v0  <= 1'b0;
            out_stb  <= 1'b0;
            pair_cnt <= 8'd0;
        end else begin
            sel     <= sel_n;
            out_stb <= pub;
            if (cap) begin
                hold_0  <= data_00;
                hold_v0 <= valid_00;
            end
            if (pub && (hold_v0 || valid_00)) begin
                pair_cnt <= pair_cnt + 8'd1;
            end
        end
    end

    demux_lane #(.DW(DW)) u_lane_0 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (pub),
        .d      (hold_0),
        .v      (hold_v0),
        .data   (data_0),
        .valid  (valid_0)
    );

    // Lane 1 takes the live input word on the publishing edge.
    demux_lane #(.DW(DW)) u_lane_1 (
        .clk_2f (clk_2f),
        .reset  (reset),
        .load   (pub),
        .d      (data_00),
        .v      (valid_00),
        .data   (data_1),
        .valid  (valid_1)
    );

endmodule

// File: tb/tb_demux_l1.sv
// Randomized scoreboard bench for demux_l1: a word-level pairing model feeds
// expected queues that a free-running monitor drains on each strobe.
module tb_demux_l1;
    import demux_pkg::*;

    localparam int DW = 8;
    localparam int W  = 2 * DW + 10;

    logic          clk_2f = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_00 = '0;
    logic          valid_00 = 1'b0;
    logic [DW-1:0] data_0;
    logic          valid_0;
    logic [DW-1:0] data_1;
    logic          valid_1;
    logic          out_stb;
    logic [7:0]    pair_cnt;

    int checks = 0;
    int errors = 0;

    // exp_q layout: {data_0, valid_0, data_1, valid_1, pair_cnt}
    logic [W-1:0] exp_q[$];
    logic         stb_q[$];

    // reference model state
    bit            slot_odd;
    bit            m_idle;
    logic [DW-1:0] pend_d;
    logic          pend_v;
    logic [DW-1:0] m_d0;
    logic [DW-1:0] m_d1;
    int            m_cnt;

    demux_l1 #(.DW(DW)) dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .data_00  (data_00),
        .valid_00 (valid_00),
        .data_0   (data_0),
        .valid_0  (valid_0),
        .data_1   (data_1),
        .valid_1  (valid_1),
        .out_stb  (out_stb),
        .pair_cnt (pair_cnt)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual d0=%h v0=%b d1=%h v1=%b cnt=%0d required d0=%h v0=%b d1=%h v1=%b cnt=%0d",
                     name, act[W-1 -: DW], act[DW+9], act[DW+8 -: DW], act[8], act[7:0],
                     exp[W-1 -: DW], exp[DW+9], exp[DW+8 -: DW], exp[8], exp[7:0]);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic model_clear();
        slot_odd = 1'b0;
        m_idle   = 1'b1;
        pend_d   = '0;
        pend_v   = 1'b0;
        m_d0     = '0;
        m_d1     = '0;
        m_cnt    = 0;
    endtask

    // Words pair up as (even slot, odd slot); an invalid word leaves its lane's data.
    task automatic model_sample(input logic [DW-1:0] d, input logic v);
        if (!slot_odd) begin
`ifdef DEMUX_L1_ALIGN_EN
            if (m_idle && !v) begin
                stb_q.push_back(1'b0);
                return;
            end
            m_idle = 1'b0;
`endif
            pend_d   = d;
            pend_v   = v;
            slot_odd = 1'b1;
            stb_q.push_back(1'b0);
        end else begin
            if (pend_v) m_d0 = pend_d;
            if (v) m_d1 = d;
            if (pend_v || v) m_cnt = (m_cnt + 1) % 256;
            if (!pend_v && !v) m_idle = 1'b1;
            exp_q.push_back({m_d0, pend_v, m_d1, v, 8'(m_cnt)});
            stb_q.push_back(1'b1);
            slot_odd = 1'b0;
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_word(input logic [DW-1:0] d, input logic v);
        data_00  = d;
        valid_00 = v;
        model_sample(d, v);
        @(negedge clk_2f);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        data_00  = DW'($urandom);
        valid_00 = 1'b1;
        @(negedge clk_2f);
        check_vec("reset_outputs", {data_0, valid_0, data_1, valid_1, pair_cnt}, '0);
        check_bit("reset_out_stb", out_stb, 1'b0);
        model_clear();
        reset = 1'b0;
    endtask

    // Monitor: pops one strobe expectation per edge, and a pair on each strobe.
    initial begin
        logic         rst_seen;
        logic         es;
        logic [W-1:0] cur;
        logic [W-1:0] act;
        cur = '0;
        forever begin
            @(posedge clk_2f);
            rst_seen = reset;
            @(negedge clk_2f);
            act = {data_0, valid_0, data_1, valid_1, pair_cnt};
            if (rst_seen) begin
                cur = '0;
            end else if (stb_q.size() > 0) begin
                es = stb_q.pop_front();
                check_bit("out_stb", out_stb, es);
                if (es) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL exp_underflow actual=strobe required=no_strobe");
                    end else begin
                        cur = exp_q.pop_front();
                        check_vec("pair", act, cur);
                    end
                end else begin
                    check_vec("hold_stable", act, cur);
                end
            end
        end
    end

    initial begin
        logic [DW-1:0] stream [8];
        stream = '{8'hff, 8'hdd, 8'hee, 8'hcc, 8'hbb, 8'h99, 8'haa, 8'h88};
        model_clear();
        @(negedge clk_2f);

        // reset then invalid random words
        do_reset();
        for (int i = 0; i < 4; i++) drive_word(DW'($urandom), 1'b0);

        // fully valid stream
        do_reset();
        for (int i = 0; i < 8; i++) drive_word(stream[i], 1'b1);
        drive_word(8'h00, 1'b0);
        drive_word(8'h00, 1'b0);

        // mixed valid/invalid pairs
        drive_word(8'h88, 1'b1);
        drive_word(8'h55, 1'b0);
        drive_word(8'h77, 1'b1);
        drive_word(DW'($urandom), 1'b0);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive_word(DW'($urandom), ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) drive_word(DW'($urandom), 1'b0);

        // counter wrap: 256 valid pairs from reset
        do_reset();
        for (int i = 0; i < 512; i++) drive_word(DW'($urandom), 1'b1);
        check_bit("cnt_wrap", (pair_cnt == 8'd0), 1'b1);

        // reset discards a half-filled pair
        do_reset();
        drive_word(8'h3c, 1'b1);
        do_reset();
        drive_word(DW'($urandom), 1'b0);
        drive_word(DW'($urandom), 1'b0);
        check_bit("no_3c_published", (data_0 == 8'h3c), 1'b0);

        // idle cycle then ff,dd starting on an odd cycle
        do_reset();
        drive_word(8'h00, 1'b0);
        drive_word(8'hff, 1'b1);
        drive_word(8'hdd, 1'b1);
        drive_word(8'h00, 1'b0);
        drive_word(8'h00, 1'b0);
        drive_word(8'h00, 1'b0);

        repeat (3) @(negedge clk_2f);
        check_bit("exp_q_drained", (exp_q.size() == 0), 1'b1);
        check_bit("stb_q_drained", (stb_q.size() == 0), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
